// File: rtl/hps_spi_bridge.sv
// HPS SPI/GPIO bridge: oversampled mode-0 SPI slave, WORD_W-bit words, several words per frame.
// Optional mid-word stall abort is enabled by defining HPS_SPI_TIMEOUT_EN.
module hps_spi_bridge #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] gp_in,
  output logic [WORD_W+15:0] gp_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              io_strobe,
  output logic              frame_err,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              fpga_enable,
  input  logic              osd_enable,
  input  logic              io_enable
);
  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic {ST_IDLE, ST_SEL} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, cs_sync_q, mosi_sync_q, vld_pipe_q;
  logic                   clk_prev_q, cs_prev_q, armed_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [WORD_W-1:0]      rx_q, tx_q, word_q;
  logic [IDX_W-1:0]       word_idx_q;
  logic                   done_q, first_q, io_strobe_q, frame_err_q, miso_q;
  logic [2:0]             en_q;

  logic                   clk_s, cs_s, mosi_s;
  logic                   clk_rise, clk_fall, cs_fall, cs_rise, last_bit;
  logic [WORD_W-1:0]      rx_d;
  logic [IDX_W-1:0]       idx_d;

  // Pin synchronisers; reset values model an idle, deselected bus.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_pipe_q  <= '0;
      clk_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      vld_pipe_q  <= {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
      clk_prev_q  <= clk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  // A select only counts once a real high cs has been seen since reset.
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign last_bit = (state_q == ST_SEL) && clk_fall && (bit_cnt_q == CNT_W'(WORD_W - 1));
  assign rx_d     = {rx_q[WORD_W-2:0], mosi_s};
  assign idx_d    = first_q ? '0 : ((&word_idx_q) ? word_idx_q : word_idx_q + IDX_W'(1));

`ifdef HPS_SPI_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit;
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      word_q      <= '0;
      word_idx_q  <= '0;
      done_q      <= 1'b0;
      first_q     <= 1'b0;
      io_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      en_q        <= '0;
`ifdef HPS_SPI_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      armed_q     <= armed_q | (vld_pipe_q[SYNC_STAGES-1] & cs_s);
      en_q        <= {io_enable, osd_enable, fpga_enable};
      io_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= last_bit;
      // Commit one cycle after the last bit, so a word finishing on deselect still lands.
      if (done_q) begin
        word_q      <= rx_q;
        io_strobe_q <= 1'b1;
        tx_q        <= gp_in;
        word_idx_q  <= idx_d;
        first_q     <= 1'b0;
      end
      if (state_q == ST_IDLE) begin
`ifdef HPS_SPI_TIMEOUT_EN
        to_cnt_q <= '0;
`endif
        if (cs_fall) begin
          state_q   <= ST_SEL;
          bit_cnt_q <= '0;
          tx_q      <= gp_in;
          first_q   <= 1'b1;
        end
      end else begin
        if (clk_rise) begin
          miso_q <= tx_q[WORD_W-1];
          tx_q   <= {tx_q[WORD_W-2:0], 1'b0};
        end
        if (clk_fall) begin
          rx_q      <= rx_d;
          bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_W'(1);
        end
`ifdef HPS_SPI_TIMEOUT_EN
        if (clk_rise || clk_fall || bit_cnt_q == '0) begin
          to_cnt_q <= '0;
        end else if (to_hit) begin
          to_cnt_q    <= '0;
          bit_cnt_q   <= '0;
          frame_err_q <= 1'b1;
          tx_q        <= gp_in;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
`endif
        if (cs_rise) begin
          state_q   <= ST_IDLE;
          miso_q    <= 1'b0;
          bit_cnt_q <= '0;
          if (bit_cnt_q != '0 && !last_bit) frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign gp_out    = {11'b0, en_q, 2'b0, word_q};
  assign word_idx  = word_idx_q;
  assign io_strobe = io_strobe_q;
  assign frame_err = frame_err_q;
  assign spi_miso  = miso_q;

endmodule

// File: tb/tb_hps_spi_bridge.sv
// Bench for hps_spi_bridge: bit-level frame model with a per-cycle compare plus literal spot checks.
`timescale 1ns/1ps
module tb_hps_spi_bridge;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int IW = 4;
  localparam int TO = 64;
  localparam int H  = 8;

  logic          sys_clk = 1'b0, reset = 1'b1;
  logic [W-1:0]  gp_in = '0;
  logic [W+15:0] gp_out;
  logic [IW-1:0] word_idx;
  logic          io_strobe, frame_err, spi_miso;
  logic          spi_mosi = 1'b0, spi_clk = 1'b0, spi_cs = 1'b1;
  logic          fpga_enable = 1'b0, osd_enable = 1'b0, io_enable = 1'b0;
  logic [39:0]   gp_out24;
  logic [IW-1:0] word_idx24;
  logic          io_strobe24, frame_err24, spi_miso24;

  hps_spi_bridge #(.WORD_W(W), .SYNC_STAGES(S), .IDX_W(IW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .reset(reset), .gp_in(gp_in), .gp_out(gp_out), .word_idx(word_idx),
    .io_strobe(io_strobe), .frame_err(frame_err), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .fpga_enable(fpga_enable), .osd_enable(osd_enable),
    .io_enable(io_enable));

  // Wide instance held deselected: only the flag placement is exercised.
  hps_spi_bridge #(.WORD_W(24), .SYNC_STAGES(S), .IDX_W(IW), .TIMEOUT_CYC(TO)) u24 (
    .sys_clk(sys_clk), .reset(reset), .gp_in(24'hABCDEF), .gp_out(gp_out24), .word_idx(word_idx24),
    .io_strobe(io_strobe24), .frame_err(frame_err24), .spi_mosi(1'b0), .spi_miso(spi_miso24),
    .spi_clk(1'b0), .spi_cs(1'b1), .fpga_enable(fpga_enable), .osd_enable(osd_enable),
    .io_enable(io_enable));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            is_err;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;
  } ev_t;

  ev_t           evq[$];
  logic [W-1:0]  miso_words[$];
  int            checks = 0, errors = 0;
  bit            chk_en = 0;
  logic [W-1:0]  m_word, m_rx, m_tx_exp, m_tx_got;
  logic [IW-1:0] m_idx, m_nidx;
  logic [2:0]    m_flags;
  bit            m_sel, m_first;
  int            m_cnt, m_last_edge, m_fall_last;
  int            n_stb = 0, n_err = 0, stb_cyc = 0, err_cyc = 0;
  bit            es, ee;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_ev(input int c, input bit err, input logic [W-1:0] w, input logic [IW-1:0] ix);
    ev_t e;
    e.cyc = c; e.is_err = err; e.word = w; e.idx = ix;
    evq.push_back(e);
  endtask

  task automatic model_clear();
    evq.delete();
    m_word = '0; m_idx = '0; m_nidx = '0; m_rx = '0;
    m_sel = 0; m_first = 0; m_cnt = 0;
  endtask

  // Flags appear one clock after being driven; reset zeroes them.
  always @(posedge sys_clk) m_flags <= reset ? 3'b0 : {io_enable, osd_enable, fpga_enable};

  always @(negedge sys_clk) begin
    if (chk_en) begin
      es = 0; ee = 0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cyc == cyc) begin
          if (evq[i].is_err) ee = 1;
          else begin es = 1; m_word = evq[i].word; m_idx = evq[i].idx; end
          evq.delete(i);
        end
      end
      if (io_strobe === 1'b1) begin n_stb++; stb_cyc = cyc; end
      if (frame_err === 1'b1) begin n_err++; err_cyc = cyc; end
      chk("io_strobe", io_strobe, es);
      chk("frame_err", frame_err, ee);
      chk("gp_out", gp_out, {11'b0, m_flags, 2'b0, m_word});
      chk("word_idx", word_idx, m_idx);
      chk("gp_out24", gp_out24, {11'b0, m_flags, 2'b0, 24'h0});
      chk("idle24", {io_strobe24, frame_err24, spi_miso24, word_idx24}, 0);
    end
  end

  // Spec-level view of a completed falling edge: shift in, complete a word at W bits.
  task automatic fall_model(input logic b);
    if (m_sel) begin
      m_rx = {m_rx[W-2:0], b};
      m_cnt++;
      if (m_cnt == W) begin
        m_nidx = m_first ? '0 : ((m_nidx == '1) ? m_nidx : m_nidx + 1'b1);
        push_ev(cyc + S + 2, 0, m_rx, m_nidx);
        chk("miso_word", m_tx_got, m_tx_exp);
        miso_words.push_back(m_tx_got);
        m_tx_exp = gp_in; m_cnt = 0; m_first = 0; m_fall_last = cyc;
      end
    end
  endtask

  task automatic deselect_now();
    spi_cs = 1'b1;
    if (m_sel && m_cnt != 0) push_ev(cyc + S + 1, 1, '0, '0);
    m_sel = 0; m_cnt = 0;
  endtask

  task automatic cs_low();
    tick(1);
    spi_cs = 1'b0;
    m_sel = 1; m_cnt = 0; m_first = 1; m_tx_exp = gp_in; m_tx_got = '0;
    tick(H);
  endtask

  task automatic cs_high();
    deselect_now();
    tick(H);
  endtask

  task automatic send_bit(input logic b, input bit desel);
    spi_mosi = b; spi_clk = 1'b1; m_last_edge = cyc;
    tick(H);
    if (m_sel) m_tx_got = {m_tx_got[W-2:0], spi_miso};
    else chk("miso_idle", spi_miso, 0);
    spi_clk = 1'b0; m_last_edge = cyc;
    fall_model(b);
    if (desel) deselect_now();
    tick(H);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_clear();
  endtask

  int s_stb, s_err, fall5;

  initial begin
    model_clear();
    tick(3);
    reset = 1'b0;
    chk_en = 1;
    chk("rst_gp_out", gp_out, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_pulses", {io_strobe, frame_err, spi_miso}, 0);

    // Idle with cs high.
    tick(100);
    chk("idle_gp_out", gp_out, 0);
    chk("idle_miso", spi_miso, 0);
    chk("idle_stb", n_stb, 0);

    // One-word frame.
    gp_in = 16'h1234; miso_words.delete(); s_stb = n_stb;
    cs_low(); send_bits(16'hA55A, 16); cs_high();
    chk("w1_word", gp_out[15:0], 16'hA55A);
    chk("w1_idx", word_idx, 0);
    chk("w1_nstb", n_stb - s_stb, 1);
    chk("w1_lat", stb_cyc - m_fall_last, 4);
    chk("w1_miso", miso_words[0], 16'h1234);

    // Three-word frame, gp_in changed mid word 1.
    gp_in = 16'hCAFE; miso_words.delete(); s_stb = n_stb;
    cs_low();
    send_bits(8'h00, 8); gp_in = 16'hBEEF; send_bits(8'h01, 8);
    send_bits(16'h0002, 16); send_bits(16'h0003, 16);
    cs_high();
    chk("w3_nstb", n_stb - s_stb, 3);
    chk("w3_idx", word_idx, 2);
    chk("w3_word", gp_out[15:0], 16'h0003);
    chk("w3_miso0", miso_words[0], 16'hCAFE);
    chk("w3_miso1", miso_words[1], 16'hBEEF);

    // Abort after 7 bits.
    s_stb = n_stb; s_err = n_err;
    cs_low(); send_bits(16'h00C3, 16); send_bits(7'h7F, 7); cs_high();
    chk("ab_nerr", n_err - s_err, 1);
    chk("ab_nstb", n_stb - s_stb, 1);
    chk("ab_word", gp_out[15:0], 16'h00C3);

    // Last falling edge and deselect on the same clock.
    s_stb = n_stb; s_err = n_err;
    cs_low(); send_bits(16'h1357 >> 1, 15); send_bit(1'b1, 1); tick(H);
    chk("sc_nstb", n_stb - s_stb, 1);
    chk("sc_nerr", n_err - s_err, 0);
    chk("sc_word", gp_out[15:0], 16'h1357);

    // Flags.
    osd_enable = 1'b1; tick(1);
    chk("osd_hi", gp_out[19], 1);
    osd_enable = 1'b0; tick(1);
    chk("osd_lo", gp_out[19], 0);
    io_enable = 1'b1; fpga_enable = 1'b1; tick(2);
    chk("io_bit20", gp_out[20], 1);
    chk("fpga_bit18", gp_out[18], 1);
    chk("io24_bit28", gp_out24[28], 1);
    chk("fpga24_bit26", gp_out24[26], 1);
    io_enable = 1'b0; fpga_enable = 1'b0; tick(2);

    // Word index saturates at 15.
    cs_low();
    for (int i = 0; i < 17; i++) send_bits(64'(i), 16);
    cs_high();
    chk("sat_idx", word_idx, 15);
    chk("sat_word", gp_out[15:0], 16'h0010);

    // Reset mid-frame: cs still low afterwards must not reselect.
    s_stb = n_stb; s_err = n_err;
    cs_low(); send_bits(3'b101, 3);
    do_reset();
    send_bits(16'hFFFF, 16); cs_high();
    chk("rm_word", gp_out, 0);
    chk("rm_nstb", n_stb - s_stb, 0);
    chk("rm_nerr", n_err - s_err, 0);

    // Stall after 5 bits, then 0x5555.
    gp_in = 16'h6B6B; s_stb = n_stb; s_err = n_err; miso_words.delete();
    cs_low(); send_bits(5'b10110, 5);
    fall5 = m_last_edge;
`ifdef HPS_SPI_TIMEOUT_EN
    if (m_sel && m_cnt != 0) begin
      push_ev(fall5 + S + 1 + TO, 1, '0, '0);
      m_cnt = 0; m_tx_exp = gp_in;
    end
`endif
    tick(70);
`ifdef HPS_SPI_TIMEOUT_EN
    chk("to_nerr", n_err - s_err, 1);
    chk("to_lat", err_cyc - fall5, S + 1 + TO);
    send_bits(16'h5555, 16); cs_high();
    chk("to_word", gp_out[15:0], 16'h5555);
    chk("to_nstb", n_stb - s_stb, 1);
`else
    chk("nto_nerr", n_err - s_err, 0);
    send_bits(16'h5555, 16); cs_high();
    chk("nto_word", gp_out[15:0], 16'hB2AA);
    chk("nto_nerr2", n_err - s_err, 1);
`endif

    tick(10);
    chk("evq_empty", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_spi_bridge.md
Name: hps_spi_bridge

Overview:
Parametrised, single-clock successor to the HPS SPI/GPIO bridge. Oversamples the HPS SPI pins in the sys_clk domain and deserialises MOSI into WORD_W-bit words, several per chip-select frame. Shifts gp_in out on MISO, one word per word slot. Presents the last received word and synchronised enable flags on gp_out, with a one-cycle io_strobe per completed word, a word index and a frame-error pulse.

Parameters:
WORD_W, 16, bits per SPI word (4..64)
SYNC_STAGES, 2, synchroniser depth on spi_clk/spi_cs/spi_mosi (>=2)
IDX_W, 4, width of word_idx
TIMEOUT_CYC, 4096, sys_clk cycles of spi_clk inactivity before mid-word abort (optional feature only)

Ports:
sys_clk  in  1  sole clock; must be >= 4x spi_clk frequency
reset  in  1  synchronous, active-high reset
gp_in  in  WORD_W  word transmitted to the HPS
gp_out  out  WORD_W+16  {11'b0, io_enable_r, osd_enable_r, fpga_enable_r, 2'b0, word_out}
word_idx  out  IDX_W  index of word_out within the current frame
io_strobe  out  1  one-cycle pulse: new word on gp_out
frame_err  out  1  one-cycle pulse: partial word discarded
spi_mosi  in  1  master data
spi_miso  out  1  slave data
spi_clk  in  1  SPI clock, idle low (mode 0)
spi_cs  in  1  high = deselected
fpga_enable, osd_enable, io_enable  in  1 each  HPS flags, registered once into gp_out

Behaviour:
- Reset: all outputs 0. Internal state cleared: bit_cnt=0, shift registers 0, enable regs 0, synchronisers reset to spi_cs=1 and spi_clk=0.
- Enable flags: registered every sys_clk; 1-cycle latency, no further synchronisation.
- SPI pins: pass through SYNC_STAGES flops. Edges are detected on the synced signals as cur vs previous.
- Select (synced cs 1->0):
  - bit_cnt=0; word_idx unchanged until the first word completes.
  - tx_shift <= gp_in.
- Rising spi_clk, selected: spi_miso <= tx_shift[WORD_W-1]; tx_shift shifts left and fills with 0. The master samples on the falling edge.
- Falling spi_clk, selected:
  - rx_shift <= {rx_shift[WORD_W-2:0], mosi}; bit_cnt++.
  - When bit_cnt==WORD_W-1, in the next cycle:
    - word_out <= {rx_shift[WORD_W-2:0], mosi}; io_strobe=1 for exactly one cycle.
    - bit_cnt=0; tx_shift <= gp_in sampled in that cycle.
    - word_idx: set to 0 for the first word of the frame, else incremented, saturating at 2^IDX_W-1.
- Latency: io_strobe asserts SYNC_STAGES+2 sys_clk cycles after the last falling pin edge.
- Deselect (synced cs 0->1):
  - spi_miso=0; bit_cnt=0.
  - If bit_cnt!=0: partial word dropped, frame_err pulse, word_out kept, no io_strobe.
  - If a word completes in the same cycle as deselect: the word is committed (io_strobe) first; no frame_err.
- Deselected: spi_clk edges ignored; spi_miso held 0.
- Reset mid-frame: state returns to reset values. The frame restarts only on the next synced select edge; an already-low cs after reset counts as no select until cs goes high then low.
- Glitch rule: cs assert and deassert within SYNC_STAGES cycles may be missed. This is allowed; no output spuriously toggles.

Optional Feature:
HPS_SPI_TIMEOUT_EN
- Defined: while selected and bit_cnt!=0, a counter counts sys_clk cycles since the last synced spi_clk edge and resets on every edge. Reaching TIMEOUT_CYC means:
  - bit_cnt=0, frame_err pulse, tx_shift <= gp_in, word_idx unchanged.
  - The next falling edge starts a new word.
- Undefined: no counter, no timeout abort; TIMEOUT_CYC unused.

Test Plan:
- Reset then idle: cs=1 for 100 cycles -> all outputs 0, spi_miso=0, no io_strobe.
- One-word frame, WORD_W=16: master sends 0xA55A, gp_in=0x1234 -> MISO bits 0x1234 MSB-first; gp_out[15:0]=0xA55A; single io_strobe SYNC_STAGES+2 cycles after the 16th falling edge; word_idx=0.
- Three-word frame: master sends 0x0001, 0x0002, 0x0003 -> three io_strobe pulses, word_idx 0,1,2; gp_in reloaded at each boundary (change gp_in to 0xBEEF before word 2, MISO word 2 = 0xBEEF).
- Abort: deselect after 7 bits of 0xFFFF following a completed word 0x00C3 -> frame_err pulse, no io_strobe, gp_out[15:0] stays 0x00C3.
- Flags: pulse osd_enable high -> gp_out[19] follows 1 cycle later; io_enable=1 -> gp_out[20]=1; WORD_W=24 run -> flags at bits 27/28 (fpga_enable at bit 26).
- With HPS_SPI_TIMEOUT_EN, TIMEOUT_CYC=64: stall spi_clk 70 cycles after bit 5 -> frame_err at cycle 64; the following 16 bits (0x5555) produce io_strobe with gp_out[15:0]=0x5555. Without the macro, the same stall produces no frame_err.
